video_timing_rx: RTL and testbench

VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

---
 rtl/video_timing_rx.sv | 249 ++++++++++++++++++++++++
 tb/tb_video_timing_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_rx.sv
// Video timing receiver: 2-cycle sync/pixel pipeline with active x/y indices,
// per-frame timing measurement and a SEARCH/TRAIN/LOCKED stability tracker.
module video_timing_rx #(
  parameter int          X_BITS  = 12,
  parameter int          Y_BITS  = 12,
  parameter logic [23:0] TIMEOUT = 24'd4000000
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [7:0]        r_out,
  output logic [7:0]        g_out,
  output logic [7:0]        b_out,
  output logic [X_BITS-1:0] x_act,
  output logic [Y_BITS-1:0] y_act,
  output logic [X_BITS-1:0] h_total,
  output logic [X_BITS-1:0] h_act,
  output logic [Y_BITS-1:0] v_total,
  output logic [Y_BITS-1:0] v_act,
  output logic              frame_start,
  output logic              locked
);

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef struct packed {
    logic [X_BITS-1:0] ht;
    logic [X_BITS-1:0] ha;
    logic [Y_BITS-1:0] vt;
    logic [Y_BITS-1:0] va;
  } meas_t;

  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

  localparam logic [X_BITS-1:0] X_MAX = '1;
  localparam logic [Y_BITS-1:0] Y_MAX = '1;
  localparam logic [X_BITS-1:0] X_ONE = {{(X_BITS-1){1'b0}}, 1'b1};
  localparam logic [Y_BITS-1:0] Y_ONE = {{(Y_BITS-1){1'b0}}, 1'b1};

  function automatic logic [X_BITS-1:0] inc_x(input logic [X_BITS-1:0] v);
    return (v == X_MAX) ? v : v + X_ONE;
  endfunction

  function automatic logic [Y_BITS-1:0] inc_y(input logic [Y_BITS-1:0] v);
    return (v == Y_MAX) ? v : v + Y_ONE;
  endfunction

  pix_t              s1;
  pix_t              s2;
  logic              sampled;
  logic              armed;
  logic              vs_rise;
  logic              hs_rise;
  logic              de_fall;

  logic [X_BITS-1:0] h_cnt;
  logic [X_BITS-1:0] h_lat;
  logic [X_BITS-1:0] d_cnt;
  logic [X_BITS-1:0] d_lat;
  logic [Y_BITS-1:0] v_cnt;
  logic [Y_BITS-1:0] va_cnt;
  meas_t             pub;
  meas_t             prev;
  logic              pub_evt;
  logic              frame_ok;
  logic              frame_same;

  state_t            state;
  logic [1:0]        match;
  logic [23:0]       to_cnt;

  // A vs that is already high when reset releases is not a real rising edge:
  // edges only count once a genuine low sample has been seen.
  assign vs_rise = s1.vs & ~s2.vs & armed;
  assign hs_rise = s1.hs & ~s2.hs;
  assign de_fall = ~s1.de & s2.de;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      sampled <= 1'b0;
      armed   <= 1'b0;
    end else begin
      s1      <= {vs_in, hs_in, de_in, r_in, g_in, b_in};
      s2      <= s1;
      sampled <= 1'b1;
      armed   <= armed | (sampled & ~s1.vs);
    end
  end

  assign {vs_out, hs_out, de_out, r_out, g_out, b_out} = s2;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      x_act <= '0;
      y_act <= '0;
    end else begin
      if (s1.de) begin
        x_act <= s2.de ? inc_x(x_act) : '0;
      end else begin
        x_act <= '0;
      end
      if (vs_rise) begin
        y_act <= '0;
      end else if (de_fall) begin
        y_act <= inc_y(y_act);
      end
    end
  end

  // Line period counts the rise cycle as 1, so the next rise sees exactly the period.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      h_cnt  <= '0;
      h_lat  <= '0;
      d_cnt  <= '0;
      d_lat  <= '0;
      v_cnt  <= '0;
      va_cnt <= '0;
    end else begin
      if (hs_rise) begin
        h_cnt <= X_ONE;
        h_lat <= h_cnt;
      end else begin
        h_cnt <= inc_x(h_cnt);
      end

      if (de_fall) begin
        d_lat <= d_cnt;
        d_cnt <= '0;
      end else if (s1.de) begin
        d_cnt <= inc_x(d_cnt);
      end

      if (vs_rise) begin
        v_cnt  <= '0;
        va_cnt <= '0;
      end else begin
        if (hs_rise) v_cnt <= inc_y(v_cnt);
        if (de_fall) va_cnt <= inc_y(va_cnt);
      end
    end
  end

  // A line edge coinciding with vs belongs to the frame that is ending.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      pub         <= '0;
      pub_evt     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pub_evt     <= vs_rise;
      frame_start <= pub_evt;
      if (vs_rise) begin
        pub.ht <= hs_rise ? h_cnt : h_lat;
        pub.ha <= de_fall ? d_cnt : d_lat;
        pub.vt <= hs_rise ? inc_y(v_cnt) : v_cnt;
        pub.va <= de_fall ? inc_y(va_cnt) : va_cnt;
      end
    end
  end

  assign h_total = pub.ht;
  assign h_act   = pub.ha;
  assign v_total = pub.vt;
  assign v_act   = pub.va;

  assign frame_ok = (pub.ht != '0) && (pub.ht != X_MAX) &&
                    (pub.ha != '0) && (pub.ha != X_MAX) &&
                    (pub.vt != '0) && (pub.vt != Y_MAX) &&
                    (pub.va != '0) && (pub.va != Y_MAX) &&
                    (pub.ha < pub.ht) && (pub.va < pub.vt);
  assign frame_same = (pub == prev);

  // The tracker evaluates the published frame one cycle after publication,
  // so locked changes on the same cycle that frame_start pulses.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state  <= SEARCH;
      match  <= '0;
      locked <= 1'b0;
      prev   <= '0;
      to_cnt <= '0;
    end else begin
      if (vs_rise) begin
        to_cnt <= '0;
      end else if (to_cnt != TIMEOUT) begin
        to_cnt <= to_cnt + 24'd1;
      end

      if (to_cnt == TIMEOUT) begin
        state  <= SEARCH;
        match  <= '0;
        locked <= 1'b0;
      end else if (pub_evt) begin
        prev <= pub;
        case (state)
          SEARCH: begin
            state  <= TRAIN;
            match  <= '0;
            locked <= 1'b0;
          end
          TRAIN: begin
            if (frame_ok && frame_same) begin
              if (match == 2'd1) begin
                state  <= LOCKED;
                match  <= 2'd2;
                locked <= 1'b1;
              end else begin
                match <= match + 2'd1;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            if (!(frame_ok && frame_same)) begin
              state  <= TRAIN;
              match  <= '0;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= SEARCH;
            match  <= '0;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: table of frame formats plus hand-written
// sequences for lock loss, timeout, reset and saturation corners.
module tb_video_timing_rx;

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] ht;
    logic [11:0] ha;
    logic [11:0] vt;
    logic [11:0] va;
    logic        fs;
    logic        lk;
  } obs_t;

  typedef struct {
    int htot, hact, vtot, vact, nfr;
    int e_ht, e_ha, e_vt, e_va, e_lock, e_lock_at, e_mx, e_my, use_long;
  } vec_t;

  logic       pix_clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic [7:0] r_in = '0, g_in = '0, b_in = '0;
  obs_t       so, lo, mo;
  bit         sel_long = 1'b0;

  int total = 0, bad = 0;
  int fs_count = 0, lock_rise_at = 0, lock_fall_at = 0, vs_sent = 0;
  int max_x = 0, max_y = 0, lag_err = 0, lag_n = 0;
  bit lag_chk = 1'b0, fs_chk = 1'b0;
  logic lk_d = 1'b0;
  logic [26:0] hist0 = '0, hist1 = '0;

  always #5 pix_clk = ~pix_clk;

  video_timing_rx #(.X_BITS(12), .Y_BITS(12), .TIMEOUT(24'd500)) u_short (
    .pix_clk(pix_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .vs_out(so.vs), .hs_out(so.hs), .de_out(so.de),
    .r_out(so.r), .g_out(so.g), .b_out(so.b),
    .x_act(so.x), .y_act(so.y), .h_total(so.ht), .h_act(so.ha),
    .v_total(so.vt), .v_act(so.va), .frame_start(so.fs), .locked(so.lk)
  );

  // Tall-frame formats need a timeout longer than one frame.
  video_timing_rx #(.X_BITS(12), .Y_BITS(12), .TIMEOUT(24'd20000)) u_long (
    .pix_clk(pix_clk), .rst(rst), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .vs_out(lo.vs), .hs_out(lo.hs), .de_out(lo.de),
    .r_out(lo.r), .g_out(lo.g), .b_out(lo.b),
    .x_act(lo.x), .y_act(lo.y), .h_total(lo.ht), .h_act(lo.ha),
    .v_total(lo.vt), .v_act(lo.va), .frame_start(lo.fs), .locked(lo.lk)
  );

  assign mo = sel_long ? lo : so;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge pix_clk) begin
    if (mo.fs) fs_count++;
    if (mo.lk && !lk_d) lock_rise_at = vs_sent;
    if (!mo.lk && lk_d) begin
      lock_fall_at = vs_sent;
      if (fs_chk) check("drop_with_frame_start", mo.fs, 1);
    end
    lk_d = mo.lk;
    if (mo.de) begin
      if (int'(mo.x) > max_x) max_x = int'(mo.x);
      if (int'(mo.y) > max_y) max_y = int'(mo.y);
    end
    if (lag_chk) begin
      lag_n++;
      if ({mo.vs, mo.hs, mo.de, mo.r, mo.g, mo.b} !== hist1) lag_err++;
    end
    hist1 = hist0;
    hist0 = {vs_in, hs_in, de_in, r_in, g_in, b_in};
  end

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic clear_stats();
    fs_count = 0; lock_rise_at = 0; lock_fall_at = 0; vs_sent = 0;
    max_x = 0; max_y = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    clear_stats();
  endtask

  // vs and hs rise together at line 0; active region starts at line 2, pixel 3.
  task automatic send_frame(input int ht, input int ha, input int vt, input int va);
    for (int l = 0; l < vt; l++) begin
      for (int p = 0; p < ht; p++) begin
        vs_in = (l < 2);
        hs_in = (p < 2);
        de_in = (l >= 2) && (l < 2 + va) && (p >= 3) && (p < 3 + ha);
        r_in  = 8'(p);
        g_in  = 8'(l);
        b_in  = 8'(p + l);
        if (l == 0 && p == 0) vs_sent++;
        tick();
      end
    end
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{20, 12, 10, 6, 4,      20, 12, 10, 6,      1, 4, 11, 5,    0};
    tbl[1] = '{30, 16, 8, 5, 4,       30, 16, 8, 5,       1, 4, 15, 4,    0};
    tbl[2] = '{20, 12, 10, 6, 3,      20, 12, 10, 6,      0, 0, 11, 5,    0};
    tbl[3] = '{8, 4, 1125, 1080, 4,   8, 4, 1125, 1080,   1, 4, 3, 1079,  1};

    do_reset();
    check("reset_outputs_zero", mo !== '0, 0);

    for (int i = 0; i < 4; i++) begin
      sel_long = (tbl[i].use_long != 0);
      do_reset();
      for (int f = 0; f < tbl[i].nfr; f++)
        send_frame(tbl[i].htot, tbl[i].hact, tbl[i].vtot, tbl[i].vact);
      check($sformatf("row%0d_h_total", i), mo.ht, tbl[i].e_ht);
      check($sformatf("row%0d_h_act", i), mo.ha, tbl[i].e_ha);
      check($sformatf("row%0d_v_total", i), mo.vt, tbl[i].e_vt);
      check($sformatf("row%0d_v_act", i), mo.va, tbl[i].e_va);
      check($sformatf("row%0d_locked", i), mo.lk, tbl[i].e_lock);
      check($sformatf("row%0d_lock_at_vs", i), lock_rise_at, tbl[i].e_lock_at);
      check($sformatf("row%0d_frame_starts", i), fs_count, tbl[i].nfr);
      check($sformatf("row%0d_max_x", i), max_x, tbl[i].e_mx);
      check($sformatf("row%0d_max_y", i), max_y, tbl[i].e_my);
    end

    // Full-width 1080p lines: x range and 2-cycle output lag.
    sel_long = 1'b0;
    do_reset();
    lag_err = 0; lag_n = 0;
    lag_chk = 1'b1;
    send_frame(2200, 1920, 3, 1);
    lag_chk = 1'b0;
    check("wide_max_x", max_x, 1919);
    check("wide_lag_errors", lag_err, 0);
    check("wide_lag_samples", lag_n >= 6600, 1);

    // One short-active frame inside a locked stream.
    do_reset();
    for (int f = 0; f < 5; f++) send_frame(20, 12, 10, 6);
    check("bad_pre_locked", mo.lk, 1);
    fs_chk = 1'b1;
    send_frame(20, 11, 10, 6);
    check("bad_still_locked", mo.lk, 1);
    send_frame(20, 12, 10, 6);
    check("bad_dropped", mo.lk, 0);
    check("bad_h_act", mo.ha, 11);
    check("bad_drop_at_vs", lock_fall_at, 7);
    send_frame(20, 12, 10, 6);
    send_frame(20, 12, 10, 6);
    check("bad_not_yet_relocked", mo.lk, 0);
    send_frame(20, 12, 10, 6);
    check("bad_relocked", mo.lk, 1);
    check("bad_relock_at_vs", lock_rise_at, 10);
    fs_chk = 1'b0;

    // vs stops: lock holds until the 500-cycle timeout expires.
    repeat (250) tick();
    check("timeout_before", mo.lk, 1);
    repeat (70) tick();
    check("timeout_after", mo.lk, 0);
    clear_stats();
    for (int f = 0; f < 4; f++) send_frame(20, 12, 10, 6);
    check("timeout_relock_at_vs", lock_rise_at, 4);

    // One-cycle reset in the middle of an active line.
    de_in = 1'b1; r_in = 8'hA5; g_in = 8'h5A; b_in = 8'h3C;
    repeat (5) tick();
    check("midline_de_out", mo.de, 1);
    rst = 1'b1;
    tick();
    check("midline_rst_zero", mo !== '0, 0);
    rst = 1'b0;
    fs_count = 0;
    repeat (5) tick();
    de_in = 1'b0;
    repeat (30) tick();
    check("midline_no_fs", fs_count, 0);
    send_frame(20, 12, 10, 6);
    check("midline_fs_after_vs", fs_count, 1);
    check("midline_locked", mo.lk, 0);

    // vs already high at reset release is not an edge.
    rst = 1'b1; vs_in = 1'b1;
    repeat (3) tick();
    fs_count = 0;
    rst = 1'b0;
    repeat (6) tick();
    vs_in = 1'b0;
    repeat (4) tick();
    check("held_vs_no_fs", fs_count, 0);
    vs_in = 1'b1;
    repeat (4) tick();
    check("held_vs_real_edge_fs", fs_count, 1);

    // Overlong active period saturates the width measurement.
    do_reset();
    vs_in = 1'b1; repeat (2) tick();
    vs_in = 1'b0; de_in = 1'b1;
    repeat (5000) tick();
    de_in = 1'b0;
    repeat (10) tick();
    vs_in = 1'b1;
    repeat (4) tick();
    check("sat_h_act", mo.ha, 4095);
    check("sat_locked", mo.lk, 0);
    check("sat_never_locked", lock_rise_at, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
